// File: rtl/pulp_clk_div_pkg.sv
// Shared definitions for the PULP clock divider controller: FSM state
// encoding and the ratio loaded at reset (ratio 1 = bypass).
package pulp_clk_div_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } clk_div_state_e;

    localparam int unsigned RESET_RATIO = 1;

endpackage

// File: rtl/pulp_clk_div_if.sv
// Ratio request handshake between a requester (master) and the clock
// divider controller (slave), plus the busy indication.
interface pulp_clk_div_if #(
    parameter int DIV_WIDTH = 8
) ();

    logic                 div_valid_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic                 div_ready_o;
    logic                 busy_o;

    modport master (output div_valid_i, div_i, input div_ready_o, busy_o);
    modport slave  (input div_valid_i, div_i, output div_ready_o, busy_o);

endinterface

// File: rtl/pulp_clk_div_core.sv
// Divider core: period counter and duty-cycle flops. The flops are loaded
// from the ratio that will be in force after the current edge, so a new
// ratio starts with a rising output exactly on its boundary edge.
// Macro PULP_CLK_DIV_ODD_EN enables 50% duty correction for odd ratios
// using an extra falling-edge flop; without it odd ratios are high for
// (N-1)/2 cycles and low for (N+1)/2.
module pulp_clk_div_core
    import pulp_clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] ratio_cur,
    input  logic [DIV_WIDTH-1:0] ratio_nxt,
    output logic                 wrap,
    output logic                 div_en,
    output logic                 clk_div
);

    localparam logic [DIV_WIDTH-1:0] RATIO_ONE = DIV_WIDTH'(RESET_RATIO);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] half;
    logic                 p_q, p_d;
    logic                 en_q, en_d;

    // High-phase length; the odd correction adds one cycle that the
    // falling-edge flop later trims by half. Cannot overflow at the max ratio.
`ifdef PULP_CLK_DIV_ODD_EN
    assign half = (ratio_nxt >> 1) + {{(DIV_WIDTH-1){1'b0}}, ratio_nxt[0]};
`else
    assign half = ratio_nxt >> 1;
`endif

    assign wrap   = (ratio_cur != RATIO_ONE) && (cnt_q == ratio_cur - 1'b1);
    assign div_en = en_q;

    // Next counter value and next state of the divided clock.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((ratio_cur == RATIO_ONE) || wrap) begin
            cnt_d = '0;
        end
        en_d = (ratio_nxt != RATIO_ONE);
        p_d  = en_d && (cnt_d < half);
    end

    // Counter, rising-edge duty flop and divider enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            p_q   <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
            en_q  <= en_d;
        end
    end

`ifdef PULP_CLK_DIV_ODD_EN
    logic odd_q, n_q, and_clk;

    // Select for the half-cycle-trimmed path, valid for the ratio in force.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= en_d & ratio_nxt[0];
        end
    end

    // Falling-edge copy of p_q; ANDing delays the rise by half a cycle.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    pulp_clock_and2 u_and_odd (
        .clk0_i (p_q),
        .clk1_i (n_q),
        .clk_o  (and_clk)
    );

    pulp_clock_mux2 u_mux_odd (
        .clk0_i    (p_q),
        .clk1_i    (and_clk),
        .clk_sel_i (odd_q),
        .clk_o     (clk_div)
    );
`else
    // Divided clock is held low whenever the divider is disabled.
    pulp_clock_and2 u_gate (
        .clk0_i (p_q),
        .clk1_i (en_q),
        .clk_o  (clk_div)
    );
`endif

endmodule

// File: rtl/pulp_clock_cells.sv
// Generic clock cells. Every gate or mux on a clock path goes through one of
// these so that the physical flow can map them onto dedicated clock cells.
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module pulp_clock_and2 (
    input  logic clk0_i,
    input  logic clk1_i,
    output logic clk_o
);
    assign clk_o = clk0_i & clk1_i;
endmodule

// File: rtl/pulp_clk_div_ctrl.sv
// Clock divider controller: ratio handshake and BYPASS/RUN/SWITCH FSM.
// A new ratio waits in SWITCH until the current period ends, then is
// loaded. Optional macro PULP_CLK_DIV_ODD_EN (see pulp_clk_div_core)
// enables 50% duty for odd ratios.
module pulp_clk_div_ctrl
    import pulp_clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            test_mode_i,
    pulp_clk_div_if.slave   bus,
    output logic            clk_o
);

    localparam logic [DIV_WIDTH-1:0] RATIO_ONE = DIV_WIDTH'(RESET_RATIO);

    clk_div_state_e       state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
    logic [DIV_WIDTH-1:0] div_next_q, div_next_d;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 accept, boundary, wrap, div_en, clk_div, clk_mid;

    assign bus.div_ready_o = (state_q != SWITCH);
    assign bus.busy_o      = (state_q == SWITCH);
    assign accept          = bus.div_valid_i && bus.div_ready_o;
    assign div_eff         = (bus.div_i == '0) ? RATIO_ONE : bus.div_i;
    // Bypass periods end on every edge; divided periods end on the wrap.
    assign boundary        = (div_cur_q == RATIO_ONE) || wrap;

    // FSM next state: capture a differing ratio, commit it at the boundary.
    always_comb begin
        state_d    = state_q;
        div_cur_d  = div_cur_q;
        div_next_d = div_next_q;
        case (state_q)
            BYPASS, RUN: begin
                if (accept && (div_eff != div_cur_q)) begin
                    state_d    = SWITCH;
                    div_next_d = div_eff;
                end
            end
            SWITCH: begin
                if (boundary) begin
                    div_cur_d = div_next_q;
                    state_d   = (div_next_q == RATIO_ONE) ? BYPASS : RUN;
                end
            end
            default: state_d = BYPASS;
        endcase
    end

    // FSM and ratio registers; reset drops any pending ratio.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BYPASS;
            div_cur_q  <= RATIO_ONE;
            div_next_q <= RATIO_ONE;
        end else begin
            state_q    <= state_d;
            div_cur_q  <= div_cur_d;
            div_next_q <= div_next_d;
        end
    end

    pulp_clk_div_core #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ratio_cur (div_cur_q),
        .ratio_nxt (div_cur_d),
        .wrap      (wrap),
        .div_en    (div_en),
        .clk_div   (clk_div)
    );

    pulp_clock_mux2 u_mux_div (
        .clk0_i    (clk_i),
        .clk1_i    (clk_div),
        .clk_sel_i (div_en),
        .clk_o     (clk_mid)
    );

    pulp_clock_mux2 u_mux_test (
        .clk0_i    (clk_mid),
        .clk1_i    (clk_i),
        .clk_sel_i (test_mode_i),
        .clk_o     (clk_o)
    );

endmodule

// File: tb/tb_pulp_clk_div_ctrl.sv
// Bench for pulp_clk_div_ctrl: a table of single-cycle vectors followed by
// hand-written sequences for odd ratios, ratio 0, test mode and reset.
`timescale 1ns/1ps
module tb_pulp_clk_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tm  = 1'b0;
    logic clk_o;

    pulp_clk_div_if #(.DIV_WIDTH(8)) bus ();

    pulp_clk_div_ctrl #(.DIV_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .test_mode_i (tm),
        .bus         (bus),
        .clk_o       (clk_o)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    logic s_rdy, s_busy, s_hi, s_lo;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       busy;
        logic       hi;
        logic       lo;
    } vec_t;

    vec_t vec [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clk_i cycle: drive inputs, sample after the rising edge and
    // after the falling edge.
    task automatic cycle(input logic t, input logic v, input logic [7:0] d);
        tm = t;
        bus.div_valid_i = v;
        bus.div_i = d;
        @(posedge clk); #2;
        s_rdy  = bus.div_ready_o;
        s_busy = bus.busy_o;
        s_hi   = clk_o;
        @(negedge clk); #2;
        s_lo   = clk_o;
    endtask

    // Expected divided clock, cycle c after the boundary, ratio n.
    function automatic logic p_of(int n, int c);
        int k;
        k = c % n;
`ifdef PULP_CLK_DIV_ODD_EN
        if (n % 2 == 1) return k < (n + 1) / 2;
`endif
        return k < n / 2;
    endfunction

    function automatic logic hi_of(int n, int c);
`ifdef PULP_CLK_DIV_ODD_EN
        if (n % 2 == 1) return p_of(n, c) && (c > 0) && p_of(n, c - 1);
`endif
        return p_of(n, c);
    endfunction

    task automatic chk_run(input string name, input int n, input int c);
        chk({name, "_hi"}, s_hi, hi_of(n, c));
        chk({name, "_lo"}, s_lo, p_of(n, c));
    endtask

    task automatic chk_bypass(input string name);
        chk({name, "_hi"}, s_hi, 1);
        chk({name, "_lo"}, s_lo, 0);
    endtask

    // Idle until busy_o drops; the last observed cycle is cycle 0 of the new ratio.
    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle(0, 0, 8'd0);
            if (!s_busy) done = 1'b1;
        end
        chk({name, "_switch_done"}, done, 1);
    endtask

    initial begin
        vec[0]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 8'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[14] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[15] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[16] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[17] = '{1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[18] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};

        bus.div_valid_i = 1'b0;
        bus.div_i = 8'd0;

        // Held in reset: bypass clock, ready, not busy.
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 8'd0);
            chk("reset_ready", s_rdy, 1);
            chk("reset_busy", s_busy, 0);
            chk_bypass("reset_clk");
        end
        rst = 1'b0;

        // Table: bypass idle, switch to 4, change to 6 at cnt 1, held valid
        // in SWITCH with another ratio, then a same-ratio request.
        for (int i = 0; i < 19; i++) begin
            cycle(0, vec[i].v, vec[i].d);
            chk($sformatf("vec%0d_ready", i), s_rdy, vec[i].rdy);
            chk($sformatf("vec%0d_busy", i), s_busy, vec[i].busy);
            chk($sformatf("vec%0d_hi", i), s_hi, vec[i].hi);
            chk($sformatf("vec%0d_lo", i), s_lo, vec[i].lo);
        end

        // Odd ratio 5 from RUN 6.
        cycle(0, 1, 8'd5);
        chk("req5_busy", s_busy, 1);
        wait_idle("req5");
        chk_run("n5_c0", 5, 0);
        for (int c = 1; c < 10; c++) begin
            cycle(0, 0, 8'd0);
            chk_run($sformatf("n5_c%0d", c), 5, c);
        end

        // Ratio 3, then ratio 0 which must act as bypass.
        cycle(0, 1, 8'd3);
        wait_idle("req3");
        chk_run("n3_c0", 3, 0);
        for (int c = 1; c < 6; c++) begin
            cycle(0, 0, 8'd0);
            chk_run($sformatf("n3_c%0d", c), 3, c);
        end
        cycle(0, 1, 8'd0);
        chk("req0_busy", s_busy, 1);
        wait_idle("req0");
        chk_bypass("div0_boundary");
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 8'd0);
            chk_bypass($sformatf("div0_c%0d", c));
            chk("div0_ready", s_rdy, 1);
        end

        // Test mode mid-RUN: immediate bypass, counter keeps running.
        cycle(0, 1, 8'd4);
        wait_idle("req4");
        chk_run("tm_c0", 4, 0);
        for (int c = 1; c < 6; c++) begin
            cycle(1, 0, 8'd0);
            chk_bypass($sformatf("tm_on_c%0d", c));
            chk("tm_ready", s_rdy, 1);
        end
        for (int c = 6; c < 10; c++) begin
            cycle(0, 0, 8'd0);
            chk_run($sformatf("tm_off_c%0d", c), 4, c);
        end

        // Reset while ratio 8 is pending.
        cycle(0, 1, 8'd8);
        chk("req8_busy", s_busy, 1);
        bus.div_valid_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_sw_busy", bus.busy_o, 0);
        chk("rst_sw_ready", bus.div_ready_o, 1);
        chk("rst_sw_clk", clk_o, clk);
        @(negedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'd0);
            chk_bypass($sformatf("rst_hold_c%0d", i));
        end
        rst = 1'b0;
        cycle(0, 1, 8'd2);
        chk("first_req_busy", s_busy, 1);
        wait_idle("req2");
        chk_run("n2_c0", 2, 0);
        for (int c = 1; c < 8; c++) begin
            cycle(0, 0, 8'd0);
            chk_run($sformatf("n2_c%0d", c), 2, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
